// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: two-flop line synchronizer, mid-bit sampling
// FSM with optional even/odd parity and one or two checked stop bits.
// Ports:
//   i_CLK          sole clock, rising edge
//   i_RST          synchronous active-high reset
//   i_SERIAL_DATA  asynchronous serial line, idle high
//   o_DATA         last received word (LSB first on the line), held between pulses
//   o_DATA_VALID   one-cycle pulse; o_DATA and error flags are valid
//   o_PARITY_ERR   parity mismatch on the flagged frame
//   o_FRAME_ERR    a stop-bit sample was low on the flagged frame
//   o_BUSY         receiver is not idle
module uart_rx_cfg #(
    parameter int unsigned CYCLES_PER_BIT = 434,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_MODE    = 0,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_SERIAL_DATA,
    output logic [DATA_BITS-1:0] o_DATA,
    output logic                 o_DATA_VALID,
    output logic                 o_PARITY_ERR,
    output logic                 o_FRAME_ERR,
    output logic                 o_BUSY
);

    localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'((CYCLES_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_BIT   = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = 1'(PARITY_MODE == 2);
    localparam logic             HAS_PARITY = 1'(PARITY_MODE != 0);

    typedef enum logic [6:0] {
        S_IDLE      = 7'b0000001,
        S_START     = 7'b0000010,
        S_DATA      = 7'b0000100,
        S_PARITY    = 7'b0001000,
        S_STOP      = 7'b0010000,
        S_DONE      = 7'b0100000,
        S_WAIT_HIGH = 7'b1000000
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           sync_q, sync_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 dperr_q, dperr_d;
    logic                 dferr_q, dferr_d;
    logic                 busy_q, busy_d;
    logic                 rx;

    // Only the second synchronizer flop feeds decisions.
    assign rx = sync_q[1];

    // Next-state, counters, data path and registered-output inputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        sync_d  = {sync_q[0], i_SERIAL_DATA};
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        dperr_d = dperr_q;
        dferr_d = dferr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx) begin
                    state_d = S_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                // Mid-start resample rejects glitches shorter than half a bit.
                if (cnt_q == HALF_BIT) begin
                    cnt_d   = '0;
                    state_d = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = HAS_PARITY ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    perr_d  = (((^shreg_q) ^ rx) != ODD_PARITY);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d = '0;
                    if (!rx) begin
                        ferr_d = 1'b1;
                    end
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                dout_d  = shreg_q;
                valid_d = 1'b1;
                dperr_d = perr_q;
                dferr_d = ferr_q;
                // A framing error may be a break; wait for the line to recover.
                state_d = ferr_q ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sync_q  <= 2'b11;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            dperr_q <= 1'b0;
            dferr_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync_q  <= sync_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            dperr_q <= dperr_d;
            dferr_q <= dferr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_DATA       = dout_q;
    assign o_DATA_VALID = valid_q;
    assign o_PARITY_ERR = dperr_q;
    assign o_FRAME_ERR  = dferr_q;
    assign o_BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: instance A (8 data, even parity, 1 stop)
// and instance B (7 data, odd parity, 2 stops), both at 16 clocks per bit.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       line_a;
    logic       line_b;
    logic [7:0] a_data;
    logic       a_valid, a_perr, a_ferr, a_busy;
    logic [6:0] b_data;
    logic       b_valid, b_perr, b_ferr, b_busy;

    int n_cmp;
    int n_err;
    int a_pulses;
    int b_pulses;
    logic [6:0] b_log_data [4];
    logic       b_log_perr [4];
    logic       b_log_ferr [4];

    uart_rx_cfg #(
        .CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)
    ) u_dut_a (
        .i_CLK(clk), .i_RST(rst), .i_SERIAL_DATA(line_a),
        .o_DATA(a_data), .o_DATA_VALID(a_valid), .o_PARITY_ERR(a_perr),
        .o_FRAME_ERR(a_ferr), .o_BUSY(a_busy)
    );

    uart_rx_cfg #(
        .CYCLES_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)
    ) u_dut_b (
        .i_CLK(clk), .i_RST(rst), .i_SERIAL_DATA(line_b),
        .o_DATA(b_data), .o_DATA_VALID(b_valid), .o_PARITY_ERR(b_perr),
        .o_FRAME_ERR(b_ferr), .o_BUSY(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle o_DATA_VALID is high; log B's frames in order.
    initial begin
        a_pulses = 0;
        b_pulses = 0;
        forever begin
            @(negedge clk);
            if (a_valid) a_pulses++;
            if (b_valid) begin
                if (b_pulses < 4) begin
                    b_log_data[b_pulses] = b_data;
                    b_log_perr[b_pulses] = b_perr;
                    b_log_ferr[b_pulses] = b_ferr;
                end
                b_pulses++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic pb);
        logic [10:0] f;
        f = {1'b1, pb, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            line_a = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_b(input logic [6:0] d, input logic pb);
        logic [10:0] f;
        f = {2'b11, pb, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            line_b = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    logic cleared;
    int   pulses_before;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        line_a = 1'b1;
        line_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_a_data",  32'(a_data),  32'h0);
        check("rst_a_valid", 32'(a_valid), 32'h0);
        check("rst_a_perr",  32'(a_perr),  32'h0);
        check("rst_a_ferr",  32'(a_ferr),  32'h0);
        check("rst_a_busy",  32'(a_busy),  32'h0);
        check("rst_b_data",  32'(b_data),  32'h0);
        check("rst_b_busy",  32'(b_busy),  32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 0xA5, even parity bit 0: clean frame
        send_a(8'hA5, 1'b0);
        repeat (8) @(negedge clk);
        check("a5_pulses", 32'(a_pulses), 32'd1);
        check("a5_data",   32'(a_data),   32'hA5);
        check("a5_perr",   32'(a_perr),   32'h0);
        check("a5_ferr",   32'(a_ferr),   32'h0);
        check("a5_busy",   32'(a_busy),   32'h0);

        // 0x3C with wrong parity bit 1
        send_a(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        check("3c_pulses", 32'(a_pulses), 32'd2);
        check("3c_data",   32'(a_data),   32'h3C);
        check("3c_perr",   32'(a_perr),   32'h1);
        check("3c_ferr",   32'(a_ferr),   32'h0);

        // False start: 4-cycle low glitch
        line_a = 1'b0;
        repeat (4) @(negedge clk);
        line_a = 1'b1;
        check("fs_busy_rose", 32'(a_busy), 32'h1);
        cleared = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!a_busy) cleared = 1'b1;
        end
        check("fs_busy_cleared", 32'(cleared), 32'h1);
        repeat (40) @(negedge clk);
        check("fs_no_pulse", 32'(a_pulses), 32'd2);
        check("fs_data_held", 32'(a_data), 32'h3C);
        check("fs_perr_held", 32'(a_perr), 32'h1);

        // Break: line low for 20 bit times
        line_a = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        check("brk_pulses", 32'(a_pulses), 32'd3);
        check("brk_data",   32'(a_data),   32'h00);
        check("brk_ferr",   32'(a_ferr),   32'h1);
        check("brk_perr",   32'(a_perr),   32'h0);
        check("brk_busy_wait", 32'(a_busy), 32'h1);
        line_a = 1'b1;
        repeat (32) @(negedge clk);
        check("brk_no_more", 32'(a_pulses), 32'd3);
        check("brk_idle",    32'(a_busy),   32'h0);
        send_a(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        check("post_brk_pulses", 32'(a_pulses), 32'd4);
        check("post_brk_data",   32'(a_data),   32'h5A);
        check("post_brk_ferr",   32'(a_ferr),   32'h0);

        // Reset during data bit 3 of 0xFF, then 0x12
        pulses_before = a_pulses;
        line_a = 1'b0;
        repeat (CPB) @(negedge clk);
        line_a = 1'b1;
        repeat (3 * CPB + CPB / 2) @(negedge clk);
        check("mid_busy", 32'(a_busy), 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_data",  32'(a_data),  32'h0);
        check("mid_rst_valid", 32'(a_valid), 32'h0);
        check("mid_rst_busy",  32'(a_busy),  32'h0);
        check("mid_rst_perr",  32'(a_perr),  32'h0);
        check("mid_rst_ferr",  32'(a_ferr),  32'h0);
        rst = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        check("mid_no_pulse", 32'(a_pulses), 32'(pulses_before));
        send_a(8'h12, 1'b0);
        repeat (8) @(negedge clk);
        check("mid_one_pulse", 32'(a_pulses), 32'(pulses_before + 1));
        check("mid_data",      32'(a_data),   32'h12);
        check("mid_perr",      32'(a_perr),   32'h0);
        check("mid_ferr",      32'(a_ferr),   32'h0);

        // Instance B: 0x55 (odd parity bit 1) and 0x2A (parity bit 0) back-to-back
        send_b(7'h55, 1'b1);
        send_b(7'h2A, 1'b0);
        repeat (8) @(negedge clk);
        check("b_pulses", 32'(b_pulses), 32'd2);
        check("b0_data",  32'(b_log_data[0]), 32'h55);
        check("b0_perr",  32'(b_log_perr[0]), 32'h0);
        check("b0_ferr",  32'(b_log_ferr[0]), 32'h0);
        check("b1_data",  32'(b_log_data[1]), 32'h2A);
        check("b1_perr",  32'(b_log_perr[1]), 32'h0);
        check("b1_ferr",  32'(b_log_ferr[1]), 32'h0);
        check("b_busy",   32'(b_busy), 32'h0);
        check("a_quiet",  32'(a_pulses), 32'(pulses_before + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
